// File: rtl/dsi_pkg.sv
// Shared types and constants for the DSI HS lane distributor and its helpers.
package dsi_pkg;

  localparam int unsigned LANE_BYTE_W = 8;
  localparam int unsigned CNT_W       = 8;

  localparam logic [LANE_BYTE_W-1:0] CLK_PATTERN = 8'b01010101;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLK_START,
    ST_CLK_PRE,
    ST_DATA_START,
    ST_DATA_WAIT,
    ST_STREAM,
    ST_DATA_TRAIL,
    ST_CLK_POST,
    ST_CLK_STOP
  } dsi_dist_state_t;

endpackage

// File: rtl/dsi_timeout_counter.sv
// Loadable decrement-to-zero counter; done is high whenever the count is zero.
module dsi_timeout_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_nxt;

  // Saturates at zero; load wins over decrement.
  always_comb begin
    cnt_nxt = cnt_q;
    if (load) begin
      cnt_nxt = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_nxt = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      done  <= 1'b1;
    end else begin
      cnt_q <= cnt_nxt;
      done  <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/dsi_lane_distributor.sv
// Splits LANES-byte beats across the HS data lanes and sequences the clock lane
// around each burst (clock up first, data lanes in lockstep, clock down last).
module dsi_lane_distributor
  import dsi_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned T_CLK_PRE  = 8,
  parameter int unsigned T_CLK_POST = 16
) (
  input  logic                         clk_sys,
  input  logic                         rst_n,
  input  logic [LANE_BYTE_W*LANES-1:0] in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [LANES-1:0]             lane_start_rqst,
  output logic [LANES-1:0]             lane_fin_rqst,
  output logic [LANE_BYTE_W*LANES-1:0] lane_data,
  input  logic [LANES-1:0]             lane_data_rqst,
  input  logic [LANES-1:0]             lane_active,
  input  logic [LANES-1:0]             lane_fin_ack,
  output logic                         clk_start_rqst,
  output logic                         clk_fin_rqst,
  output logic [LANE_BYTE_W-1:0]       clk_lane_data,
  input  logic                         clk_data_rqst,
  input  logic                         clk_active,
  input  logic                         clk_fin_ack,
  output logic                         busy,
  output logic                         burst_done,
  output logic                         underflow
);

  localparam int unsigned DATA_W = LANE_BYTE_W * LANES;

  dsi_dist_state_t state_q;
  dsi_dist_state_t state_nxt;

  logic [DATA_W-1:0] lane_data_nxt;
  logic [LANES-1:0]  fin_seen_q;
  logic [LANES-1:0]  fin_seen_nxt;
  logic              start_p;
  logic              fin_p;
  logic              clk_start_p;
  logic              clk_fin_p;
  logic              done_p;
  logic              uflow_p;
  logic              pre_load;
  logic              post_load;
  logic              pre_done;
  logic              post_done;
  logic              all_rqst;
  logic              accepting;

  assign all_rqst      = &lane_data_rqst;
  assign accepting     = (state_q == ST_DATA_WAIT) || (state_q == ST_STREAM);
  assign in_ready      = accepting && all_rqst;
  assign clk_lane_data = CLK_PATTERN;

  dsi_timeout_counter #(.W(CNT_W)) u_pre_cnt (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .load     (pre_load),
    .load_val (CNT_W'(T_CLK_PRE)),
    .en       (state_q == ST_CLK_PRE),
    .done     (pre_done)
  );

  dsi_timeout_counter #(.W(CNT_W)) u_post_cnt (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .load     (post_load),
    .load_val (CNT_W'(T_CLK_POST)),
    .en       (state_q == ST_CLK_POST),
    .done     (post_done)
  );

  // Next state plus next values of the registered pulse outputs.
  always_comb begin
    state_nxt     = state_q;
    lane_data_nxt = lane_data;
    fin_seen_nxt  = fin_seen_q;
    start_p       = 1'b0;
    fin_p         = 1'b0;
    clk_start_p   = 1'b0;
    clk_fin_p     = 1'b0;
    done_p        = 1'b0;
    uflow_p       = 1'b0;
    pre_load      = 1'b0;
    post_load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && !clk_active && !(|lane_active)) begin
          state_nxt   = ST_CLK_START;
          clk_start_p = 1'b1;
        end
      end
      ST_CLK_START: begin
        if (clk_data_rqst) begin
          state_nxt = ST_CLK_PRE;
          pre_load  = 1'b1;
        end
      end
      ST_CLK_PRE: begin
        if (pre_done) begin
          state_nxt = ST_DATA_START;
          start_p   = 1'b1;
        end
      end
      ST_DATA_START: begin
        state_nxt = ST_DATA_WAIT;
      end
      ST_DATA_WAIT, ST_STREAM: begin
        // A lane request with no beat still advances; lanes get a zero byte.
        if (all_rqst) begin
          if (in_valid) begin
            lane_data_nxt = in_data;
            if (in_last) begin
              fin_p     = 1'b1;
              state_nxt = ST_DATA_TRAIL;
            end else begin
              state_nxt = ST_STREAM;
            end
          end else begin
            lane_data_nxt = '0;
            uflow_p       = 1'b1;
            state_nxt     = ST_STREAM;
          end
        end
      end
      ST_DATA_TRAIL: begin
        fin_seen_nxt = fin_seen_q | lane_fin_ack;
        if (&fin_seen_nxt) begin
          fin_seen_nxt = '0;
          state_nxt    = ST_CLK_POST;
          post_load    = 1'b1;
        end
      end
      ST_CLK_POST: begin
        if (post_done) begin
          state_nxt = ST_CLK_STOP;
          clk_fin_p = 1'b1;
        end
      end
      ST_CLK_STOP: begin
        if (clk_fin_ack) begin
          state_nxt = ST_IDLE;
          done_p    = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      lane_data       <= '0;
      fin_seen_q      <= '0;
      lane_start_rqst <= '0;
      lane_fin_rqst   <= '0;
      clk_start_rqst  <= 1'b0;
      clk_fin_rqst    <= 1'b0;
      busy            <= 1'b0;
      burst_done      <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      lane_data       <= lane_data_nxt;
      fin_seen_q      <= fin_seen_nxt;
      lane_start_rqst <= {LANES{start_p}};
      lane_fin_rqst   <= {LANES{fin_p}};
      clk_start_rqst  <= clk_start_p;
      clk_fin_rqst    <= clk_fin_p;
      busy            <= (state_nxt != ST_IDLE);
      burst_done      <= done_p;
      underflow       <= uflow_p;
    end
  end

endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Directed bench for dsi_lane_distributor with simple clock/data lane models.
module tb_dsi_lane_distributor;

  logic        clk_sys;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [3:0]  lane_start_rqst;
  logic [3:0]  lane_fin_rqst;
  logic [31:0] lane_data;
  logic [3:0]  lane_data_rqst;
  logic [3:0]  lane_active;
  logic [3:0]  lane_fin_ack;
  logic        clk_start_rqst;
  logic        clk_fin_rqst;
  logic [7:0]  clk_lane_data;
  logic        clk_data_rqst;
  logic        clk_active;
  logic        clk_fin_ack;
  logic        busy;
  logic        burst_done;
  logic        underflow;

  dsi_lane_distributor #(.LANES(4), .T_CLK_PRE(8), .T_CLK_POST(16)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .lane_start_rqst(lane_start_rqst), .lane_fin_rqst(lane_fin_rqst), .lane_data(lane_data),
    .lane_data_rqst(lane_data_rqst), .lane_active(lane_active), .lane_fin_ack(lane_fin_ack),
    .clk_start_rqst(clk_start_rqst), .clk_fin_rqst(clk_fin_rqst), .clk_lane_data(clk_lane_data),
    .clk_data_rqst(clk_data_rqst), .clk_active(clk_active), .clk_fin_ack(clk_fin_ack),
    .busy(busy), .burst_done(burst_done), .underflow(underflow)
  );

  typedef struct packed {
    logic        gap;
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t      fq[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] cap [0:3][0:15];
  int         ncap, fin_cnt, fin_idx, uf_cnt, done_cnt, cs_cnt;
  int         t_cs, t_ls, t_cf, t_ack, t_done1;
  logic [3:0] fin_val;
  logic       acc_prev, rq_prev, pres_gap;
  int         dcnt, ccnt, ctr;
  int         trail [0:3];
  int         extra [0:3];
  logic       clk_act_m, clk_hold;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic clear_stats();
    ncap = 0; fin_cnt = 0; fin_idx = -1; fin_val = '0; uf_cnt = 0;
    done_cnt = 0; cs_cnt = 0; t_cs = -1; t_ls = -1; t_cf = -1; t_ack = -1; t_done1 = -1;
  endtask

  task automatic clear_model();
    lane_data_rqst = '0; lane_active = '0; lane_fin_ack = '0;
    clk_data_rqst = 1'b0; clk_act_m = 1'b0; clk_active = 1'b0; clk_fin_ack = 1'b0;
    dcnt = 0; ccnt = 0; ctr = 0;
    for (int i = 0; i < 4; i++) trail[i] = 0;
    fq.delete();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    acc_prev = 1'b0; rq_prev = 1'b0; pres_gap = 1'b0;
  endtask

  task automatic push(input logic gap, input logic last, input logic [31:0] d);
    beat_t b;
    b = {gap, last, d};
    fq.push_back(b);
  endtask

  // Monitor, lane models and beat feeder; inputs change at negedge, sampled 1 ns before posedge.
  initial begin
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (rq_prev && ncap < 16) begin
        for (int i = 0; i < 4; i++) cap[i][ncap] = lane_data[8*i +: 8];
        ncap++;
        if (lane_fin_rqst != '0) fin_idx = ncap;
      end
      if (lane_fin_rqst != '0) begin fin_cnt++; fin_val = lane_fin_rqst; end
      if (underflow) uf_cnt++;
      if (burst_done) begin
        if (done_cnt == 0) t_done1 = cyc;
        done_cnt++;
      end
      if (clk_start_rqst) begin cs_cnt++; t_cs = cyc; end
      if (lane_start_rqst == 4'hF) t_ls = cyc;
      if (clk_fin_rqst) t_cf = cyc;

      lane_fin_ack = '0;
      clk_fin_ack  = 1'b0;
      if (lane_start_rqst == 4'hF) begin
        lane_active = 4'hF; dcnt = 2;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) lane_data_rqst = 4'hF;
      end
      if (lane_fin_rqst == 4'hF) begin
        lane_data_rqst = '0;
        for (int i = 0; i < 4; i++) trail[i] = 3 + extra[i];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (trail[i] > 0) begin
            trail[i]--;
            if (trail[i] == 0) begin
              lane_fin_ack[i] = 1'b1; lane_active[i] = 1'b0; t_ack = cyc;
            end
          end
        end
      end
      if (clk_start_rqst) begin
        clk_act_m = 1'b1; ccnt = 2;
      end else if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) clk_data_rqst = 1'b1;
      end
      if (clk_fin_rqst) begin
        clk_data_rqst = 1'b0; ctr = 3;
      end else if (ctr > 0) begin
        ctr--;
        if (ctr == 0) begin clk_fin_ack = 1'b1; clk_act_m = 1'b0; end
      end
      clk_active = clk_act_m | clk_hold;

      if (fq.size() > 0 && (acc_prev || pres_gap)) void'(fq.pop_front());
      if (fq.size() > 0) begin
        in_valid = ~fq[0].gap; in_last = fq[0].last; in_data = fq[0].data; pres_gap = fq[0].gap;
      end else begin
        in_valid = 1'b0; in_last = 1'b0; pres_gap = 1'b0;
      end

      #4;
      acc_prev = in_valid && in_ready;
      rq_prev  = &lane_data_rqst;
    end
  end

  task automatic wait_done(input int n, input string nm);
    int k;
    k = 0;
    while (done_cnt < n && k < 400) begin @(posedge clk_sys); k++; end
    repeat (3) @(posedge clk_sys);
    checks++;
    if (done_cnt !== n) begin
      failures++; $display("FAIL %s_done got=%0d want=%0d", nm, done_cnt, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if ({busy, in_ready, underflow, burst_done, clk_start_rqst, clk_fin_rqst,
         lane_start_rqst, lane_fin_rqst, lane_data} !== '0) begin
      failures++; $display("FAIL reset_outputs busy=%b rdy=%b data=%h start=%h fin=%h", busy, in_ready, lane_data, lane_start_rqst, lane_fin_rqst);
    end
    checks++;
    if (clk_lane_data !== 8'h55) begin
      failures++; $display("FAIL reset_clk_pattern got=%h want=55", clk_lane_data);
    end
    @(posedge clk_sys); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
  endtask

  task automatic test_three_beat();
    clear_stats();
    push(1'b0, 1'b0, 32'h03020100);
    push(1'b0, 1'b0, 32'h07060504);
    push(1'b0, 1'b1, 32'h0B0A0908);
    wait_done(1, "three_beat");
    checks++;
    if (ncap !== 3) begin failures++; $display("FAIL three_beat_count got=%0d want=3", ncap); end
    checks++;
    if ({cap[0][0], cap[0][1], cap[0][2]} !== 24'h000408) begin
      failures++; $display("FAIL three_beat_lane0 got=%h want=000408", {cap[0][0], cap[0][1], cap[0][2]});
    end
    checks++;
    if ({cap[3][0], cap[3][1], cap[3][2]} !== 24'h03070B) begin
      failures++; $display("FAIL three_beat_lane3 got=%h want=03070b", {cap[3][0], cap[3][1], cap[3][2]});
    end
    checks++;
    if (fin_idx !== 3 || fin_cnt !== 1 || fin_val !== 4'hF) begin
      failures++; $display("FAIL three_beat_fin idx=%0d cnt=%0d val=%h want 3/1/f", fin_idx, fin_cnt, fin_val);
    end
    checks++;
    if (t_ls - t_cs !== 12) begin
      failures++; $display("FAIL three_beat_pre gap=%0d want=12", t_ls - t_cs);
    end
    checks++;
    if (uf_cnt !== 0) begin failures++; $display("FAIL three_beat_underflow got=%0d want=0", uf_cnt); end
  endtask

  task automatic test_single_beat();
    clear_stats();
    push(1'b0, 1'b1, 32'hDDCCBBAA);
    wait_done(1, "single_beat");
    checks++;
    if (ncap !== 1 || {cap[3][0], cap[2][0], cap[1][0], cap[0][0]} !== 32'hDDCCBBAA) begin
      failures++; $display("FAIL single_beat_bytes n=%0d got=%h want=ddccbbaa", ncap, {cap[3][0], cap[2][0], cap[1][0], cap[0][0]});
    end
    checks++;
    if (fin_idx !== 1) begin failures++; $display("FAIL single_beat_fin idx=%0d want=1", fin_idx); end
    checks++;
    if (t_cf - t_ack !== 18) begin failures++; $display("FAIL single_beat_post gap=%0d want=18", t_cf - t_ack); end
  endtask

  task automatic test_underflow();
    clear_stats();
    push(1'b0, 1'b0, 32'h13121110);
    push(1'b1, 1'b0, 32'h0);
    push(1'b1, 1'b0, 32'h0);
    push(1'b0, 1'b1, 32'h17161514);
    wait_done(1, "underflow");
    checks++;
    if (uf_cnt !== 2) begin failures++; $display("FAIL underflow_pulses got=%0d want=2", uf_cnt); end
    checks++;
    if (ncap !== 4 || {cap[0][0], cap[0][1], cap[0][2], cap[0][3]} !== 32'h10000014) begin
      failures++; $display("FAIL underflow_lane0 n=%0d got=%h want=10000014", ncap, {cap[0][0], cap[0][1], cap[0][2], cap[0][3]});
    end
    checks++;
    if (fin_idx !== 4) begin failures++; $display("FAIL underflow_fin idx=%0d want=4", fin_idx); end
  endtask

  task automatic test_stagger();
    clear_stats();
    extra[2] = 3;
    push(1'b0, 1'b1, 32'h33323130);
    wait_done(1, "stagger");
    extra[2] = 0;
    checks++;
    if (t_cf - t_ack !== 18) begin failures++; $display("FAIL stagger_post gap=%0d want=18", t_cf - t_ack); end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    push(1'b0, 1'b0, 32'h23222120);
    push(1'b0, 1'b1, 32'h27262524);
    push(1'b0, 1'b1, 32'h2B2A2928);
    wait_done(2, "back_to_back");
    checks++;
    if (cs_cnt !== 2 || t_cs - t_done1 !== 1) begin
      failures++; $display("FAIL b2b_restart starts=%0d gap=%0d want 2/1", cs_cnt, t_cs - t_done1);
    end
    checks++;
    if (ncap !== 3 || {cap[0][0], cap[0][1], cap[0][2]} !== 24'h202428 || fin_cnt !== 2) begin
      failures++; $display("FAIL b2b_bytes n=%0d got=%h fins=%0d want 3/202428/2", ncap, {cap[0][0], cap[0][1], cap[0][2]}, fin_cnt);
    end
  endtask

  task automatic test_stream_reset();
    int k;
    clear_stats();
    for (int i = 0; i < 5; i++) push(1'b0, 1'b0, 32'h40404040 + 32'(i));
    push(1'b0, 1'b1, 32'h4F4F4F4F);
    k = 0;
    while (ncap < 2 && k < 200) begin @(posedge clk_sys); k++; end
    @(posedge clk_sys); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL stream_reset_ready rdy=%b busy=%b want 0/0", in_ready, busy);
    end
    checks++;
    if ({underflow, burst_done, clk_start_rqst, clk_fin_rqst, lane_start_rqst, lane_fin_rqst, lane_data} !== '0) begin
      failures++; $display("FAIL stream_reset_outputs data=%h fin=%h", lane_data, lane_fin_rqst);
    end
    clear_model();
    clear_stats();
    repeat (3) @(posedge clk_sys); #2;
    rst_n = 1'b1;
    push(1'b0, 1'b0, 32'h53525150);
    push(1'b0, 1'b1, 32'h57565554);
    wait_done(1, "stream_reset_restart");
    checks++;
    if (ncap !== 2 || {cap[1][0], cap[1][1]} !== 16'h5155) begin
      failures++; $display("FAIL stream_reset_restart_bytes n=%0d got=%h want=5155", ncap, {cap[1][0], cap[1][1]});
    end
  endtask

  task automatic test_clk_hold();
    clear_stats();
    clk_hold = 1'b1;
    repeat (2) @(posedge clk_sys);
    push(1'b0, 1'b1, 32'h63626160);
    repeat (8) @(posedge clk_sys);
    #1;
    checks++;
    if (cs_cnt !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL clk_hold_blocked starts=%0d busy=%b want 0/0", cs_cnt, busy);
    end
    clk_hold = 1'b0;
    wait_done(1, "clk_hold");
    checks++;
    if (cs_cnt !== 1 || ncap !== 1 || cap[2][0] !== 8'h62) begin
      failures++; $display("FAIL clk_hold_release starts=%0d n=%0d b=%h want 1/1/62", cs_cnt, ncap, cap[2][0]);
    end
  endtask

  initial begin
    clk_hold = 1'b0;
    for (int i = 0; i < 4; i++) extra[i] = 0;
    clear_model();
    clear_stats();
    test_reset();
    test_three_beat();
    test_single_beat();
    test_underflow();
    test_stagger();
    test_back_to_back();
    test_stream_reset();
    test_clk_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
